regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (write_data / write_register / RegWrite) between two writeback sources.
- Source A: single-cycle ALU pipeline; no backpressure, priority.
- Source B: long-latency units (mul/div, load); valid/ready, buffered in a FIFO.
- Keeps a 32-bit busy scoreboard of registers with outstanding B writes, for decode hazard checks.
- Sits between the execute/memory stages and the register file.

Parameters:
DEPTH, 4, B-side FIFO entries (power of two, >=2)
MAX_WAIT, 8, cycles a non-empty FIFO head may be blocked by A before a_stall is raised (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
a_valid  input  1  A write request this cycle
a_addr  input  5  A destination register
a_data  input  32  A write data
a_stall  output  1  registered; pipeline must not present a_valid while high
b_valid  input  1  B write request
b_ready  output  1  FIFO can accept (registered, = count<DEPTH)
b_addr  input  5  B destination register
b_data  input  32  B write data
issue_set  input  1  long-latency op issued; mark issue_addr busy
issue_addr  input  5  destination of issued op
busy  output  32  scoreboard; bit n = outstanding B write to register n
wr_en  output  1  to RegWrite
wr_addr  output  5  to write_register
wr_data  output  32  to write_data
fifo_count  output  clog2(DEPTH)+1  FIFO occupancy
err_drop  output  1  one-cycle pulse: A request dropped (protocol violation)

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, a_stall=0, b_ready=1 (cycle after reset), busy=0, fifo_count=0, err_drop=0, wait counter=0. Reset mid-operation discards FIFO contents and scoreboard.
- Output register: wr_* registered. Arbiter selection at cycle t appears on wr_* at t+1. wr_en high exactly one cycle per write.
- B handshake:
  - Transfer when b_valid & b_ready; entry is pushed into FIFO.
  - b_ready = (count < DEPTH), registered, updated from the next-state count.
  - Simultaneous push and pop is allowed whenever b_ready=1.
- Arbitration per cycle, in priority order:
  1. a_stall=1: pop FIFO head to output. If a_valid is also high, A is dropped and err_drop pulses.
  2. a_valid=1: A goes to output; FIFO head waits.
  3. FIFO non-empty: pop head to output.
  4. Otherwise: wr_en=0 next cycle.
- Starvation:
  - Wait counter increments each cycle FIFO is non-empty and no pop occurs; clears on any pop or when FIFO is empty.
  - When counter reaches MAX_WAIT, a_stall=1 for exactly the next cycle, and that cycle pops the head.
- Latency: A write is visible at t+1. B accepted at t, FIFO empty, A idle: wr_en at t+2.
- Register 0:
  - Any selected write with addr 0 is consumed (popped / A accepted) but wr_en stays 0.
  - issue_set to 0 is ignored; busy[0] is always 0.
- Scoreboard:
  - issue_set sets busy[issue_addr] next cycle.
  - A B pop with addr n clears busy[n] in the same cycle wr_en rises.
  - Set and clear of the same bit in the same cycle: set wins.
  - A writes never touch busy.
- FIFO pointers wrap modulo DEPTH. Pushing while full is impossible by handshake; b_valid with b_ready=0 is ignored.

Optional Feature:
WB_BYPASS_EN:
- Defined: if FIFO is empty, a_valid=0, a_stall=0 and a B transfer occurs at t, the B write skips the FIFO and is selected directly, giving wr_en at t+1. fifo_count does not change. Scoreboard clear timing is the same as for a pop.
- Undefined: all B writes pass through the FIFO, with minimum latency 2.

Test Plan:
- A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF at t -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF at t+1; busy unchanged.
- B only: issue_set addr 9, then B write addr 9 data 0x1234 with A idle -> busy[9]=1 until the write; wr_en at t+2 (t+1 with WB_BYPASS_EN); busy[9]=0 that same cycle.
- Contention / starvation, MAX_WAIT=8: B pushes addr 3, A valid every cycle -> B blocked 8 cycles, a_stall=1 for one cycle, B write addr 3 appears, no err_drop while A honours the stall; driving a_valid during a_stall -> err_drop pulse.
- Full FIFO, DEPTH=4: push 4 entries with A busy -> b_ready=0, fifo_count=4; a 5th b_valid is not accepted; draining returns writes in FIFO order.
- r0 handling: A addr 0 and B addr 0 writes -> wr_en stays 0, FIFO pops; issue_set addr 0 -> busy[0]=0.
- Reset mid-stream: FIFO count 3, busy=0x0000_0208, assert rst one cycle -> next cycle count 0, busy 0, wr_en 0, b_ready 1 thereafter.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: priority ALU source A, FIFO-buffered long-latency source B,
// starvation guard and busy scoreboard. Define WB_BYPASS_EN to let B skip an empty FIFO.
module regfile_wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    input  logic [4:0]                 a_addr,
    input  logic [31:0]                a_data,
    output logic                       a_stall,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_addr,
    input  logic [31:0]                b_data,
    input  logic                       issue_set,
    input  logic [4:0]                 issue_addr,
    output logic [31:0]                busy,
    output logic                       wr_en,
    output logic [4:0]                 wr_addr,
    output logic [31:0]                wr_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [WW-1:0] wait_cnt, wait_next;
    logic [CW-1:0] count_next;
    logic          fifo_empty, bypass, push, pop, sel, sel_b;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;
    logic [31:0]   set_mask, clr_mask;

    assign fifo_empty = (fifo_count == '0);

`ifdef WB_BYPASS_EN
    assign bypass = fifo_empty & ~a_valid & ~a_stall & b_valid & b_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = b_valid & b_ready & ~bypass;

    always_comb begin
        pop      = 1'b0;
        sel      = 1'b0;
        sel_b    = 1'b0;
        sel_addr = fifo_addr[rd_ptr];
        sel_data = fifo_data[rd_ptr];
        if (a_stall) begin
            // A is held off this cycle; any a_valid now is a dropped request
            pop   = ~fifo_empty;
            sel   = ~fifo_empty;
            sel_b = ~fifo_empty;
        end else if (a_valid) begin
            sel      = 1'b1;
            sel_addr = a_addr;
            sel_data = a_data;
        end else if (!fifo_empty) begin
            pop   = 1'b1;
            sel   = 1'b1;
            sel_b = 1'b1;
        end else if (bypass) begin
            sel      = 1'b1;
            sel_b    = 1'b1;
            sel_addr = b_addr;
            sel_data = b_data;
        end
    end

    assign count_next = fifo_count + CW'(push) - CW'(pop);

    always_comb begin
        wait_next = wait_cnt;
        if (fifo_empty || pop)
            wait_next = '0;
        else if (wait_cnt < WW'(MAX_WAIT))
            wait_next = wait_cnt + WW'(1);
    end

    assign set_mask = issue_set ? (32'd1 << issue_addr) : 32'd0;
    assign clr_mask = sel_b     ? (32'd1 << sel_addr)   : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            wait_cnt   <= '0;
            a_stall    <= 1'b0;
            b_ready    <= 1'b1;
            busy       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            err_drop   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= count_next;
            b_ready    <= (count_next < CW'(DEPTH));
            wait_cnt   <= wait_next;
            a_stall    <= (wait_next == WW'(MAX_WAIT));
            err_drop   <= a_stall & a_valid;
            // set beats clear on the same bit; r0 is never tracked
            busy       <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
            wr_en      <= sel & (sel_addr != 5'd0);
            if (sel) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= b_addr;
            fifo_data[wr_ptr] <= b_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register writes queued at drive time,
// matched in order by a write monitor; control outputs checked with immediate assertions.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, issue_set = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0, issue_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_stall, b_ready, wr_en, err_drop;
    logic [31:0] busy, wr_data;
    logic [4:0]  wr_addr;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_stall(a_stall),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .issue_set(issue_set), .issue_addr(issue_addr), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fifo_count(fifo_count), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Write monitor: every register-file write must match the head of the expected queue
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            logic [36:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                assert ({wr_addr, wr_data} === e) else begin
                    failures++;
                    $error("FAIL write_order observed=%0h:%0h expected=%0h:%0h",
                           wr_addr, wr_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_err_drop", err_drop, 0);

        // A only
        a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF; expect_wr(5, 32'hDEADBEEF);
        tick();
        a_valid = 0;
        chk("a_wr_en", wr_en, 1);
        chk("a_wr_addr", wr_addr, 5);
        chk("a_wr_data", wr_data, 32'hDEADBEEF);
        chk("a_busy", busy, 0);

        // B only with scoreboard
        issue_set = 1; issue_addr = 9;
        tick();
        issue_set = 0;
        chk("b_busy_set", busy, 32'h200);
        chk("b_ready_idle", b_ready, 1);
        b_valid = 1; b_addr = 9; b_data = 32'h1234; expect_wr(9, 32'h1234);
        tick();
        b_valid = 0;
`ifndef WB_BYPASS_EN
        chk("b_lat_wr_en0", wr_en, 0);
        chk("b_lat_count1", fifo_count, 1);
        chk("b_busy_hold", busy, 32'h200);
        tick();
`endif
        chk("b_wr_en", wr_en, 1);
        chk("b_wr_addr", wr_addr, 9);
        chk("b_busy_clr", busy, 0);
        chk("b_count0", fifo_count, 0);

        // starvation with A honouring the stall
        for (int i = 0; i < 9; i++) begin
            a_valid = 1; a_addr = 20; a_data = 100 + i; expect_wr(20, 100 + i);
            b_valid = (i == 0); b_addr = 3; b_data = 32'h33;
            tick();
            b_valid = 0;
            if (i < 8) chk("stall_early", a_stall, 0);
        end
        chk("stall_raised", a_stall, 1);
        chk("stall_count", fifo_count, 1);
        a_valid = 0; expect_wr(3, 32'h33);
        tick();
        chk("stall_one_cycle", a_stall, 0);
        chk("stall_no_drop", err_drop, 0);
        chk("stall_b_addr", wr_addr, 3);
        chk("stall_count0", fifo_count, 0);

        // starvation with A violating the stall
        for (int i = 0; i < 9; i++) begin
            a_valid = 1; a_addr = 21; a_data = 150 + i; expect_wr(21, 150 + i);
            b_valid = (i == 0); b_addr = 4; b_data = 32'h44;
            tick();
            b_valid = 0;
        end
        chk("drop_stall", a_stall, 1);
        a_addr = 22; a_data = 32'hBAD; expect_wr(4, 32'h44);
        tick();
        a_valid = 0;
        chk("drop_pulse", err_drop, 1);
        chk("drop_b_addr", wr_addr, 4);
        tick();
        chk("drop_pulse_end", err_drop, 0);

        // fill FIFO while A is busy
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_addr = 25; a_data = 200 + i; expect_wr(25, 200 + i);
            b_valid = 1; b_addr = 5'(11 + i); b_data = 32'h1100 + i;
            tick();
        end
        chk("full_ready", b_ready, 0);
        chk("full_count", fifo_count, 4);
        a_data = 204; expect_wr(25, 204);
        b_addr = 15; b_data = 32'h1199;
        tick();
        a_valid = 0; b_valid = 0;
        chk("full_reject", fifo_count, 4);
        for (int i = 0; i < 4; i++) expect_wr(5'(11 + i), 32'h1100 + i);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_addr", wr_addr, 11 + i);
            if (i == 0) chk("drain_ready", b_ready, 1);
        end
        chk("drain_count", fifo_count, 0);

        // register 0
        a_valid = 1; a_addr = 0; a_data = 32'h55;
        tick();
        a_valid = 0;
        chk("r0_a_wr_en", wr_en, 0);
        b_valid = 1; b_addr = 0; b_data = 32'h66;
        tick();
        b_valid = 0;
`ifndef WB_BYPASS_EN
        chk("r0_b_queued", fifo_count, 1);
`endif
        tick();
        chk("r0_b_wr_en", wr_en, 0);
        chk("r0_b_popped", fifo_count, 0);
        issue_set = 1; issue_addr = 0;
        tick();
        issue_set = 0;
        chk("r0_busy", busy, 0);

        // reset mid-stream
        issue_set = 1; issue_addr = 3;
        tick();
        issue_addr = 9;
        tick();
        issue_set = 0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_addr = 26; a_data = 300 + i; expect_wr(26, 300 + i);
            b_valid = 1; b_addr = 5'(7 + i); b_data = 32'h700 + i;
            tick();
        end
        a_valid = 0; b_valid = 0;
        chk("mid_count", fifo_count, 3);
        chk("mid_busy", busy, 32'h208);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_ready", b_ready, 1);
        tick();
        chk("post_rst_ready", b_ready, 1);
        chk("post_rst_wr_en", wr_en, 0);
        chk("post_rst_count", fifo_count, 0);
        tick(); tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
